// File: rtl/fdtd_jz_source_gen.sv
// fdtd_jz_source_gen: recursive-oscillator Jz source sampler with step limit; FDTD_SRC_RAMP_EN adds a linear turn-on ramp
module fdtd_jz_source_gen #(
  parameter int data_width = 64,
  parameter int frac_width = 21,
  parameter int coef_width = 32,
  parameter int ramp_log2 = 6
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clken,
  input  logic                         start,
  input  logic signed [coef_width-1:0] coef_2cos,
  input  logic signed [data_width-1:0] amp_sin,
  input  logic [31:0]                  num_steps,
  input  logic                         step_start,
  output logic signed [data_width-1:0] Jz,
  output logic                         jz_valid,
  output logic                         busy,
  output logic                         done
);
  typedef enum logic [2:0] {IDLE, RUN, CALC1, CALC2, DONE} state_t;
  localparam int pw = data_width + coef_width;
  state_t state, nxt;
  logic signed [coef_width-1:0] coef;
  logic signed [data_width-1:0] s_prev, s_cur, s_next, env;
  logic signed [pw-1:0] p, coef_x, cur_x;
  logic [pw:0] p_sh, prev_x, diff;
  logic [31:0] nsteps, step_cnt;
  logic ok;
  assign coef_x = {{data_width{coef[coef_width-1]}}, coef};
  assign cur_x = {{coef_width{s_cur[data_width-1]}}, s_cur};
  assign p_sh = {{(coef_width-1){p[pw-1]}}, p[pw-1:coef_width-2]};
  assign prev_x = {{(coef_width+1){s_prev[data_width-1]}}, s_prev};
  assign diff = p_sh - prev_x;
  assign ok = &diff[pw:data_width-1] | ~|diff[pw:data_width-1];
  assign s_next = ok ? diff[data_width-1:0] : {diff[pw], {(data_width-1){~diff[pw]}}};
`ifdef FDTD_SRC_RAMP_EN
  localparam int rw = data_width + ramp_log2 + 1;
  logic signed [rw-1:0] rp;
  assign rp = $signed({{(ramp_log2+1){s_cur[data_width-1]}}, s_cur}) * $signed({{(data_width+1){1'b0}}, step_cnt[ramp_log2-1:0]});
  assign env = step_cnt < (32'd1 << ramp_log2) ? rp[ramp_log2 +: data_width] : s_cur;
`else
  assign env = s_cur;
`endif
  assign busy = state == CALC1 || state == CALC2;
  assign done = state == DONE;
  always_comb begin
    nxt = start ? (num_steps == 32'd0 ? DONE : RUN)
        : state == RUN && step_start ? CALC1
        : state == CALC1 ? CALC2
        : state == CALC2 ? (step_cnt + 32'd1 == nsteps ? DONE : RUN)
        : state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      coef <= '0;
      s_prev <= '0;
      s_cur <= '0;
      p <= '0;
      nsteps <= '0;
      step_cnt <= '0;
      Jz <= '0;
      jz_valid <= 1'b0;
    end else if (clken) begin
      state <= nxt;
      jz_valid <= !start && state == CALC2;
      if (start) begin
        s_prev <= '0;
        s_cur <= amp_sin;
        step_cnt <= '0;
        coef <= coef_2cos;
        nsteps <= num_steps;
        Jz <= '0;
      end else if (state == CALC1) begin
        p <= coef_x * cur_x;
      end else if (state == CALC2) begin
        Jz <= env;
        s_prev <= s_cur;
        s_cur <= s_next;
        step_cnt <= step_cnt + 32'd1;
      end else if (state == DONE) begin
        Jz <= '0;
      end
    end
  end
endmodule

// File: tb/tb_fdtd_jz_source_gen.sv
// tb_fdtd_jz_source_gen: randomized and directed checks of the Jz source against a sample-sequence model
module tb_fdtd_jz_source_gen;
  localparam int rl = 2;
  localparam logic signed [127:0] mx = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] mn = ~mx;
  logic clock = 0, reset = 1, clken = 1, start = 0, step_start = 0;
  logic [31:0] coef_2cos = 0, num_steps = 0;
  logic [63:0] amp_sin = 0;
  logic [63:0] Jz;
  logic jz_valid, busy, done;
  int total = 0, bad = 0;
  logic [63:0] exp_q[$];
  always #5 clock = ~clock;
  fdtd_jz_source_gen #(.ramp_log2(rl)) dut (
    .clock(clock), .reset(reset), .clken(clken), .start(start),
    .coef_2cos(coef_2cos), .amp_sin(amp_sin), .num_steps(num_steps),
    .step_start(step_start), .Jz(Jz), .jz_valid(jz_valid), .busy(busy), .done(done)
  );
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  function automatic void build(input logic signed [31:0] c, input logic signed [63:0] a, input int n);
    logic signed [127:0] prev, cur, nx, e;
    exp_q.delete();
    prev = 0;
    cur = a;
    for (int k = 0; k < n; k++) begin
      e = cur;
`ifdef FDTD_SRC_RAMP_EN
      if (k < (1 << rl)) e = (cur * k) >>> rl;
`endif
      exp_q.push_back(e[63:0]);
      nx = ((cur * c) >>> 30) - prev;
      if (nx > mx) nx = mx;
      else if (nx < mn) nx = mn;
      prev = cur;
      cur = nx;
    end
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic load(input logic [31:0] c, input logic [63:0] a, input logic [31:0] n);
    coef_2cos = c;
    amp_sin = a;
    num_steps = n;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic step(output logic [63:0] got, output int lat);
    step_start = 1;
    tick();
    step_start = 0;
    lat = 0;
    while (!jz_valid && lat < 20) begin
      tick();
      lat++;
    end
    got = Jz;
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (3) tick();
    total++; if (Jz !== 0) begin bad++; $display("FAIL reset_jz got=%h exp=0", Jz); end
    total++; if (jz_valid !== 0) begin bad++; $display("FAIL reset_valid got=%b exp=0", jz_valid); end
    total++; if (busy !== 0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 0;
    tick();
  endtask
  task automatic test_quarter_wave();
`ifdef FDTD_SRC_RAMP_EN
    logic [63:0] tbl[5] = '{64'h0, 64'h0, 64'hFFFF_FFFF_FFF0_0000, 64'h0, 64'h20_0000};
`else
    logic [63:0] tbl[5] = '{64'h20_0000, 64'h0, 64'hFFFF_FFFF_FFE0_0000, 64'h0, 64'h20_0000};
`endif
    logic [63:0] got;
    int lat;
    load(32'h0, 64'h20_0000, 5);
    for (int k = 0; k < 5; k++) begin
      step(got, lat);
      total++; if (got !== tbl[k]) begin bad++; $display("FAIL quarter[%0d] got=%h exp=%h", k, got, tbl[k]); end
      total++; if (lat !== 2) begin bad++; $display("FAIL quarter_lat[%0d] got=%0d exp=2", k, lat); end
    end
    total++; if (done !== 1) begin bad++; $display("FAIL quarter_done got=%b exp=1", done); end
    tick();
    total++; if (Jz !== 0) begin bad++; $display("FAIL quarter_jz_zero got=%h exp=0", Jz); end
    total++; if (jz_valid !== 0) begin bad++; $display("FAIL quarter_no_valid got=%b exp=0", jz_valid); end
  endtask
  task automatic test_sixth_wave();
`ifdef FDTD_SRC_RAMP_EN
    logic [63:0] tbl[6] = '{64'h0, 64'h8_0000, 64'h0, 64'hFFFF_FFFF_FFE8_0000, 64'hFFFF_FFFF_FFE0_0000, 64'h0};
`else
    logic [63:0] tbl[6] = '{64'h20_0000, 64'h20_0000, 64'h0, 64'hFFFF_FFFF_FFE0_0000, 64'hFFFF_FFFF_FFE0_0000, 64'h0};
`endif
    logic [63:0] got;
    int lat;
    load(32'h4000_0000, 64'h20_0000, 6);
    for (int k = 0; k < 6; k++) begin
      step(got, lat);
      total++; if (got !== tbl[k]) begin bad++; $display("FAIL sixth[%0d] got=%h exp=%h", k, got, tbl[k]); end
    end
    total++; if (done !== 1) begin bad++; $display("FAIL sixth_done got=%b exp=1", done); end
  endtask
  task automatic test_saturation();
`ifdef FDTD_SRC_RAMP_EN
    logic [63:0] e2 = 64'h1FFF_FFFF_FFFF_FFFF;
`else
    logic [63:0] e2 = 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    logic [63:0] got;
    int lat;
    load(32'h7FFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 3);
    step(got, lat);
    step(got, lat);
    total++; if (got !== e2) begin bad++; $display("FAIL saturation got=%h exp=%h", got, e2); end
  endtask
  task automatic test_random();
    logic [63:0] got;
    logic [31:0] c;
    logic [63:0] a;
    int lat, n;
    for (int it = 0; it < 6; it++) begin
      c = $urandom;
      a = {$urandom, $urandom} >> $urandom_range(40);
      n = $urandom_range(8, 1);
      build(c, a, n);
      load(c, a, n);
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(2)) tick();
        step(got, lat);
        total++; if (got !== exp_q[k]) begin bad++; $display("FAIL random[%0d][%0d] got=%h exp=%h", it, k, got, exp_q[k]); end
      end
      total++; if (done !== 1) begin bad++; $display("FAIL random_done[%0d] got=%b exp=1", it, done); end
    end
  endtask
  task automatic test_ignore_busy();
    int cnt;
    load(32'h0, 64'h20_0000, 3);
    step_start = 1;
    tick();
    total++; if (busy !== 1) begin bad++; $display("FAIL busy_calc1 got=%b exp=1", busy); end
    tick();
    tick();
    step_start = 0;
    cnt = int'(jz_valid);
    repeat (6) begin
      tick();
      cnt += int'(jz_valid);
    end
    total++; if (cnt !== 1) begin bad++; $display("FAIL ignore_busy_pulses got=%0d exp=1", cnt); end
  endtask
  task automatic test_clken_stall();
    logic [63:0] e0;
    int cyc;
    build(32'h0, 64'h31_4159, 3);
    e0 = exp_q[0];
    load(32'h0, 64'h31_4159, 3);
    step_start = 1;
    tick();
    step_start = 0;
    clken = 0;
    repeat (4) tick();
    total++; if (busy !== 1) begin bad++; $display("FAIL stall_busy got=%b exp=1", busy); end
    clken = 1;
    cyc = 4;
    while (!jz_valid && cyc < 30) begin
      tick();
      cyc++;
    end
    total++; if (cyc !== 6) begin bad++; $display("FAIL stall_latency got=%0d exp=6", cyc); end
    total++; if (Jz !== e0) begin bad++; $display("FAIL stall_value got=%h exp=%h", Jz, e0); end
    clken = 0;
    repeat (2) tick();
    total++; if (jz_valid !== 1) begin bad++; $display("FAIL stall_valid_hold got=%b exp=1", jz_valid); end
    clken = 1;
    tick();
    total++; if (jz_valid !== 0) begin bad++; $display("FAIL stall_valid_drop got=%b exp=0", jz_valid); end
  endtask
  task automatic test_zero_steps();
    int cnt = 0;
    load(32'h0, 64'h20_0000, 0);
    total++; if (done !== 1) begin bad++; $display("FAIL zero_done got=%b exp=1", done); end
    total++; if (Jz !== 0) begin bad++; $display("FAIL zero_jz got=%h exp=0", Jz); end
    step_start = 1;
    tick();
    step_start = 0;
    repeat (4) begin
      cnt += int'(jz_valid);
      tick();
    end
    total++; if (cnt !== 0 || done !== 1) begin bad++; $display("FAIL zero_ignore valid=%0d done=%b exp=0/1", cnt, done); end
  endtask
  task automatic test_reset_mid();
    logic [63:0] got;
    int lat, cnt = 0;
    load(32'h0, 64'h20_0000, 5);
    step(got, lat);
    step_start = 1;
    tick();
    step_start = 0;
    reset = 1;
    tick();
    reset = 0;
    total++; if (Jz !== 0) begin bad++; $display("FAIL rstmid_jz got=%h exp=0", Jz); end
    total++; if (jz_valid !== 0 || busy !== 0 || done !== 0) begin bad++; $display("FAIL rstmid_flags got=%b%b%b exp=000", jz_valid, busy, done); end
    step_start = 1;
    tick();
    step_start = 0;
    repeat (4) begin
      cnt += int'(jz_valid);
      tick();
    end
    total++; if (cnt !== 0) begin bad++; $display("FAIL rstmid_no_valid got=%0d exp=0", cnt); end
  endtask
  task automatic test_restart();
    logic [63:0] got;
    int lat;
    load(32'h4000_0000, 64'h12_3456, 5);
    step(got, lat);
    step(got, lat);
    build(32'h0, 64'h0A_BCDE, 2);
    coef_2cos = 0;
    amp_sin = 64'h0A_BCDE;
    num_steps = 2;
    start = 1;
    step_start = 1;
    tick();
    start = 0;
    step_start = 0;
    total++; if (busy !== 0) begin bad++; $display("FAIL restart_priority busy=%b exp=0", busy); end
    step(got, lat);
    total++; if (got !== exp_q[0]) begin bad++; $display("FAIL restart_value got=%h exp=%h", got, exp_q[0]); end
    total++; if (lat !== 2) begin bad++; $display("FAIL restart_lat got=%0d exp=2", lat); end
  endtask
  initial begin
    test_reset();
    test_quarter_wave();
    test_sixth_wave();
    test_saturation();
    test_random();
    test_ignore_busy();
    test_clken_stall();
    test_zero_steps();
    test_reset_mid();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
